// File: rtl/cpu_pkg.sv
// cpu_pkg: shared entry point, memory depth and loader state encoding.
// Rev 1.0
`default_nettype none

package cpu_pkg;

  localparam logic [31:0] DEFAULT_ENTRY_PC = 32'h28;
  localparam int          IMEM_WORDS       = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } load_state_t;

endpackage

`default_nettype wire

// File: rtl/word_packer.sv
// word_packer: assembles little-endian bytes into a 32-bit word buffer.
// Rev 1.0
`default_nettype none

module word_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [7:0]  i_data,
  output logic [31:0] o_word,
  output logic [1:0]  o_idx,
  output logic        o_full,
  output logic        o_partial
);

  logic [31:0] r_word;
  logic [1:0]  r_idx;

  // Clear wins over push so an abandoned word never leaks bytes into the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word <= 32'h0;
      r_idx  <= 2'd0;
    end else if (i_clear) begin
      r_word <= 32'h0;
      r_idx  <= 2'd0;
    end else if (i_push) begin
      r_word[8*r_idx +: 8] <= i_data;
      r_idx                <= r_idx + 2'd1;
    end
  end

  assign o_word    = r_word;
  assign o_idx     = r_idx;
  assign o_full    = (r_idx == 2'd3);
  assign o_partial = (r_idx != 2'd0);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// imem_loader: packs a host byte stream into words and writes instruction memory,
// then reports completion and the start PC. Rev 1.0
`default_nettype none

module imem_loader
  import cpu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_ENTRY_PC,
  parameter int          MAX_WORDS = IMEM_WORDS,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] word_count,
  output logic [31:0]      pc_start
);

  load_state_t      r_state;
  load_state_t      w_next;
  logic [CNT_W-1:0] r_word_count;
  logic             r_error;
  logic             r_last;

  logic        w_accept;
  logic        w_word_end;
  logic        w_room;
  logic        w_start_ok;
  logic        w_clear;
  logic        w_push;
  logic [31:0] w_word;
  logic [1:0]  w_idx;
  logic        w_full;
  logic        w_partial;

  word_packer u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (w_clear),
    .i_push    (w_push),
    .i_data    (in_data),
    .o_word    (w_word),
    .o_idx     (w_idx),
    .o_full    (w_full),
    .o_partial (w_partial)
  );

  assign w_accept   = in_valid & in_ready;
  assign w_word_end = w_accept & (w_full | in_last);
  assign w_room     = (r_word_count < CNT_W'(MAX_WORDS));
  assign w_start_ok = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    w_push  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next  = ST_LOAD;
          w_clear = 1'b1;
        end
      end
      ST_LOAD: begin
        w_push = w_accept;
        if (w_word_end) begin
          if (w_room) begin
            w_next = ST_WRITE;
          end else begin
            // Out of memory: drop the buffered word and swallow the rest of the stream.
            w_next  = in_last ? ST_DONE : ST_DRAIN;
            w_clear = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        w_clear = 1'b1;
        w_next  = r_last ? ST_DONE : ST_LOAD;
      end
      ST_DRAIN: begin
        if (w_accept && in_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_next  = ST_LOAD;
          w_clear = 1'b1;
        end
      end
      default: begin
        w_next  = ST_IDLE;
        w_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_word_count <= '0;
      r_error      <= 1'b0;
      r_last       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_word_count <= '0;
        r_error      <= 1'b0;
        r_last       <= 1'b0;
      end else begin
        if ((r_state == ST_LOAD) && w_word_end) begin
          r_last <= in_last;
          if (!w_room) begin
            r_error <= 1'b1;
          end
        end
        if (r_state == ST_WRITE) begin
          r_word_count <= r_word_count + CNT_W'(1);
        end
      end
    end
  end

  assign in_ready   = (r_state == ST_LOAD) | (r_state == ST_DRAIN);
  assign busy       = (r_state == ST_LOAD) | (r_state == ST_WRITE) | (r_state == ST_DRAIN);
  assign mem_we     = (r_state == ST_WRITE);
  assign done       = (r_state == ST_DONE);
  assign error      = r_error;
  assign word_count = r_word_count;
  assign pc_start   = BASE_ADDR;

  // Address and data are only meaningful alongside the strobe; zero elsewhere.
  assign mem_addr  = mem_we ? (BASE_ADDR + (32'(r_word_count) << 2)) : 32'h0;
  assign mem_wdata = mem_we ? w_word : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench; dut1 uses defaults, dut2 has MAX_WORDS=2.
// Rev 1.0
`default_nettype none

module tb_imem_loader;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start, in_valid, in_last, sel;
  logic [7:0] in_data;

  logic        s1, v1, s2, v2;
  logic        rdy1, we1, busy1, done1, err1;
  logic        rdy2, we2, busy2, done2, err2;
  logic [31:0] addr1, wd1, pc1, addr2, wd2, pc2;
  logic [15:0] wc1, wc2;
  logic        w_rdy, w_done;

  assign s1 = start & ~sel;
  assign v1 = in_valid & ~sel;
  assign s2 = start & sel;
  assign v2 = in_valid & sel;
  assign w_rdy  = sel ? rdy2 : rdy1;
  assign w_done = sel ? done2 : done1;

  imem_loader dut1 (
    .clk(clk), .reset_n(reset_n), .start(s1), .in_valid(v1), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wd1), .busy(busy1), .done(done1), .error(err1),
    .word_count(wc1), .pc_start(pc1)
  );

  imem_loader #(.MAX_WORDS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(s2), .in_valid(v2), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy2), .mem_we(we2), .mem_addr(addr2),
    .mem_wdata(wd2), .busy(busy2), .done(done2), .error(err2),
    .word_count(wc2), .pc_start(pc2)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int stalls = 0;
  int both_hi = 0;
  logic [31:0] qa1[$], qd1[$], qa2[$], qd2[$];

  always @(negedge clk) begin
    if (we1) begin
      qa1.push_back(addr1);
      qd1.push_back(wd1);
      if (rdy1) both_hi++;
    end
    if (we2) begin
      qa2.push_back(addr2);
      qd2.push_back(wd2);
      if (rdy2) both_hi++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents a byte and returns at the negedge after the accepting edge; valid stays high.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    t = 0;
    while (!w_rdy && t < 50) begin
      @(negedge clk);
      stalls++;
      t++;
    end
    n_cmp++;
    if (!w_rdy) begin
      n_fail++;
      $display("FAIL handshake byte=%h: in_ready stayed 0, required 1", d);
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (!w_done && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (w_done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout: done=%b, required 1", w_done);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; start = 1'b0; idle_in();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({rdy1, we1, busy1, done1, err1} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b, required 00000", {rdy1, we1, busy1, done1, err1}); end
    n_cmp++; if ({addr1, wd1, wc1} !== 80'h0) begin n_fail++; $display("FAIL reset_data: addr=%h wdata=%h wc=%0d, required 0", addr1, wd1, wc1); end
    n_cmp++; if (pc1 !== 32'h28) begin n_fail++; $display("FAIL reset_pc: got %h, required 00000028", pc1); end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({rdy1, busy1, done1} !== 3'b0) begin n_fail++; $display("FAIL idle_flags: got %b, required 000", {rdy1, busy1, done1}); end
  endtask

  task automatic test_single_word();
    int base;
    sel = 1'b0; base = qa1.size();
    pulse_start();
    n_cmp++; if ({rdy1, busy1} !== 2'b11) begin n_fail++; $display("FAIL load_flags: got %b, required 11", {rdy1, busy1}); end
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h50, 1'b0);
    send_byte(8'h00, 1'b1);
    n_cmp++; if ({we1, done1, rdy1} !== 3'b100) begin n_fail++; $display("FAIL latency_n1: we/done/rdy=%b, required 100", {we1, done1, rdy1}); end
    @(negedge clk);
    idle_in();
    n_cmp++; if ({we1, done1, busy1} !== 3'b010) begin n_fail++; $display("FAIL latency_n2: we/done/busy=%b, required 010", {we1, done1, busy1}); end
    n_cmp++; if (qa1.size() - base !== 1) begin n_fail++; $display("FAIL single_count: %0d writes, required 1", qa1.size() - base); end
    n_cmp++; if (qa1[base] !== 32'h28 || qd1[base] !== 32'h00500093) begin n_fail++; $display("FAIL single_write: %h:%h, required 00000028:00500093", qa1[base], qd1[base]); end
    n_cmp++; if (wc1 !== 16'd1 || err1 !== 1'b0) begin n_fail++; $display("FAIL single_status: wc=%0d err=%b, required 1/0", wc1, err1); end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [7:0] bytes [8];
    sel = 1'b0; base = qa1.size(); stalls = 0; both_hi = 0;
    bytes = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h33, 8'h85, 8'hA5, 8'h00};
    pulse_start();
    n_cmp++; if (done1 !== 1'b0 || wc1 !== 16'd0) begin n_fail++; $display("FAIL restart_clear: done=%b wc=%0d, required 0/0", done1, wc1); end
    for (int i = 0; i < 8; i++) send_byte(bytes[i], i == 7);
    wait_done(10);
    idle_in();
    n_cmp++; if (qa1.size() - base !== 2) begin n_fail++; $display("FAIL b2b_count: %0d writes, required 2", qa1.size() - base); end
    n_cmp++; if (qa1[base] !== 32'h28 || qd1[base] !== 32'h00A00513) begin n_fail++; $display("FAIL b2b_word0: %h:%h, required 00000028:00A00513", qa1[base], qd1[base]); end
    n_cmp++; if (qa1[base+1] !== 32'h2C || qd1[base+1] !== 32'h00A58533) begin n_fail++; $display("FAIL b2b_word1: %h:%h, required 0000002C:00A58533", qa1[base+1], qd1[base+1]); end
    n_cmp++; if (wc1 !== 16'd2) begin n_fail++; $display("FAIL b2b_wc: got %0d, required 2", wc1); end
    n_cmp++; if (stalls !== 1) begin n_fail++; $display("FAIL b2b_stalls: got %0d, required 1", stalls); end
    n_cmp++; if (both_hi !== 0) begin n_fail++; $display("FAIL b2b_ready_in_write: %0d cycles, required 0", both_hi); end
  endtask

  task automatic test_partial();
    int base;
    sel = 1'b0; base = qa1.size();
    pulse_start();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    wait_done(10);
    idle_in();
    n_cmp++; if (qa1.size() - base !== 1) begin n_fail++; $display("FAIL partial_count: %0d writes, required 1", qa1.size() - base); end
    n_cmp++; if (qa1[base] !== 32'h28 || qd1[base] !== 32'h00CCBBAA) begin n_fail++; $display("FAIL partial_write: %h:%h, required 00000028:00CCBBAA", qa1[base], qd1[base]); end
    n_cmp++; if (wc1 !== 16'd1) begin n_fail++; $display("FAIL partial_wc: got %0d, required 1", wc1); end
  endtask

  task automatic test_overflow();
    int base1;
    sel = 1'b1; base1 = qa1.size();
    pulse_start();
    for (int i = 1; i <= 12; i++) send_byte(8'(i), 1'b0);
    n_cmp++; if ({rdy2, busy2, err2, we2} !== 4'b1110) begin n_fail++; $display("FAIL drain_flags: rdy/busy/err/we=%b, required 1110", {rdy2, busy2, err2, we2}); end
    send_byte(8'h0D, 1'b0);
    send_byte(8'h0E, 1'b1);
    wait_done(10);
    idle_in();
    n_cmp++; if (qa2.size() !== 2) begin n_fail++; $display("FAIL ovf_count: %0d writes, required 2", qa2.size()); end
    n_cmp++; if (qa2[0] !== 32'h28 || qd2[0] !== 32'h04030201) begin n_fail++; $display("FAIL ovf_word0: %h:%h, required 00000028:04030201", qa2[0], qd2[0]); end
    n_cmp++; if (qa2[1] !== 32'h2C || qd2[1] !== 32'h08070605) begin n_fail++; $display("FAIL ovf_word1: %h:%h, required 0000002C:08070605", qa2[1], qd2[1]); end
    n_cmp++; if ({done2, err2} !== 2'b11 || wc2 !== 16'd2) begin n_fail++; $display("FAIL ovf_status: done/err=%b wc=%0d, required 11/2", {done2, err2}, wc2); end
    n_cmp++; if (qa1.size() !== base1) begin n_fail++; $display("FAIL ovf_isolation: dut1 wrote %0d words, required 0", qa1.size() - base1); end
    pulse_start();
    n_cmp++; if ({err2, done2} !== 2'b00) begin n_fail++; $display("FAIL ovf_restart_clear: err/done=%b, required 00", {err2, done2}); end
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b1);
    wait_done(10);
    idle_in();
    n_cmp++; if (qa2.size() !== 3 || qa2[2] !== 32'h28 || qd2[2] !== 32'h12345678) begin n_fail++; $display("FAIL ovf_reload: n=%0d %h:%h, required 3 00000028:12345678", qa2.size(), qa2[2], qd2[2]); end
    n_cmp++; if (err2 !== 1'b0 || wc2 !== 16'd1) begin n_fail++; $display("FAIL ovf_reload_status: err=%b wc=%0d, required 0/1", err2, wc2); end
  endtask

  task automatic test_reset_mid_load();
    int base;
    sel = 1'b0; base = qa1.size();
    pulse_start();
    send_byte(8'hFF, 1'b0);
    send_byte(8'hEE, 1'b0);
    idle_in();
    n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b, required 1", busy1); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if ({rdy1, we1, busy1, done1, err1} !== 5'b0 || wc1 !== 16'd0) begin n_fail++; $display("FAIL async_reset: flags=%b wc=%0d, required 00000/0", {rdy1, we1, busy1, done1, err1}, wc1); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pulse_start();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    wait_done(10);
    idle_in();
    n_cmp++; if (qa1.size() - base !== 1) begin n_fail++; $display("FAIL post_reset_count: %0d writes, required 1", qa1.size() - base); end
    n_cmp++; if (qa1[base] !== 32'h28 || qd1[base] !== 32'h44332211) begin n_fail++; $display("FAIL post_reset_write: %h:%h, required 00000028:44332211", qa1[base], qd1[base]); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_partial();
    test_overflow();
    test_reset_mid_load();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the instruction-fetch stage. Receives a program as a little-endian byte stream, packs it into 32-bit words, and writes them into instruction memory starting at the entry point (default 0x28).
- Once the load completes, signals the core that it may start and supplies the start PC.
- Sits between the host/debug byte link and the instruction-memory write port of yIF.

Parameters:
- BASE_ADDR, 32'h28, byte address of the first instruction word; also driven on pc_start.
- MAX_WORDS, 64, instruction-memory capacity in words; writes beyond it are suppressed.
- CNT_W, 16, width of word_count (must satisfy 2^CNT_W > MAX_WORDS).

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a new load.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  program byte, little-endian within each word.
- in_last  input  1  qualifies the final byte of the program.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  32  byte address of the word being written.
- mem_wdata  output  32  packed instruction word.
- busy  output  1  load in progress.
- done  output  1  load finished; held until the next start.
- error  output  1  overflow occurred during the last load; held until the next start.
- word_count  output  CNT_W  number of words actually written.
- pc_start  output  32  constant BASE_ADDR; the core samples it when done rises.

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0 except pc_start=BASE_ADDR. Byte index, word index and word buffer are cleared. mem_we drops immediately, and a write in flight is abandoned.
- States: IDLE, LOAD, WRITE, DRAIN, DONE.
- IDLE/DONE + start -> LOAD. Entering LOAD clears word_count, done, error, byte index and buffer. In any other state, start is ignored.
- LOAD:
  - in_ready=1, busy=1.
  - A byte is accepted when in_valid && in_ready. It is stored at buffer[8*idx+7 : 8*idx], and idx increments (mod 4).
  - On acceptance of byte idx=3, or of any byte with in_last=1: if word_count < MAX_WORDS go to WRITE, otherwise set error=1 and go to DRAIN (or to DONE if in_last was set).
  - A partial final word keeps zero in its unwritten upper bytes.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr = BASE_ADDR + 4*word_count, mem_wdata = buffer, in_ready=0.
  - Next cycle: word_count increments, buffer and idx clear. Next state is DONE if the word carried last, otherwise LOAD.
  - Latency: the final byte is accepted at edge N; mem_we is high in cycle N+1; done is high from cycle N+2.
- DRAIN: in_ready=1. Bytes are accepted and discarded, with no writes, until a byte with in_last=1 is accepted; then go to DONE.
- DONE: done=1, busy=0, in_ready=0. word_count and error are held.
- in_last on a byte with idx=3 produces exactly one write (no extra zero word).
- A byte with in_valid high while in_ready=0 is not consumed. The source holds it; this is the standard valid/ready rule, and the source must not drop valid without a handshake.
- mem_addr wraps modulo 2^32. With default parameters this is unreachable.
- mem_we is never asserted outside WRITE.

Decomposition:
- Shared package (cpu_pkg): DEFAULT_ENTRY_PC = 32'h28, IMEM_WORDS = 64, and the loader state enum, so that the testbench and top level share the entry point.
- One sub-module, word_packer: byte index counter, 32-bit buffer, full/partial flags, synchronous clear. The FSM and address generation stay in imem_loader.

Test Plan:
- start, then bytes 93,00,50,00 (last on 00) -> single mem_we at 0x28 with data 0x00500093; then done=1, word_count=1, error=0.
- Two words 13,05,A0,00 / 33,85,A5,00 (last) -> writes 0x28:0x00A00513 and 0x2C:0x00A58533; word_count=2.
- Partial word AA,BB,CC (last) -> mem_wdata 0x00CCBBAA at 0x28; word_count=1.
- MAX_WORDS=2, send 3 full words -> writes only at 0x28 and 0x2C; remaining bytes drained with in_ready=1; done=1, error=1, word_count=2.
- in_valid held high continuously -> in_ready=0 during each WRITE cycle; no byte lost or duplicated (checked against the golden word sequence).
- reset_n low mid-LOAD after 2 bytes -> all outputs 0 and in_ready=0 asynchronously. A subsequent start and 4-byte word is written at 0x28 with only the new bytes.
